// File: rtl/parking_slot_manager_if.sv
// Gate-request and status bundle between the gate logic and parking_slot_manager.
interface parking_slot_manager_if #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned TIME_W    = 32,
    parameter int unsigned FEE_W     = 32
);
    localparam int unsigned ID_W  = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    logic              entry_req;
    logic              exit_req;
    logic [ID_W-1:0]   exit_id;
    logic              busy;
    logic              entry_ack;
    logic [ID_W-1:0]   entry_id;
    logic              entry_reject;
    logic              exit_reject;
    logic              fee_valid;
    logic [FEE_W-1:0]  fee;
    logic [CNT_W-1:0]  car_count;
    logic              full;
    logic              empty;
    logic [TIME_W-1:0] cur_time;

    modport master (
        output entry_req, exit_req, exit_id,
        input  busy, entry_ack, entry_id, entry_reject, exit_reject,
               fee_valid, fee, car_count, full, empty, cur_time
    );

    modport slave (
        input  entry_req, exit_req, exit_id,
        output busy, entry_ack, entry_id, entry_reject, exit_reject,
               fee_valid, fee, car_count, full, empty, cur_time
    );
endinterface

// File: rtl/parking_slot_manager.sv
// Parking lot bay manager: lowest-free allocation, per-bay entry timestamps,
// occupancy count, prescaled time base and a pipelined saturating fee.
module parking_slot_manager #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned TIME_W    = 32,
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned RATE      = 1,
    parameter int unsigned FEE_W     = 32
) (
    input logic                   clk,
    input logic                   rst,
    parking_slot_manager_if.slave bus
);
    localparam int unsigned ID_W   = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PROD_W = TIME_W + 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENT,
        S_XCHK,
        S_XSUB,
        S_XMUL
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SLOTS-1:0] occ;
    logic [TIME_W-1:0]   stamp [NUM_SLOTS];
    logic [PRE_W-1:0]    presc;
    logic [TIME_W-1:0]   cur_time;
    logic [TIME_W-1:0]   t_exit;
    logic [TIME_W-1:0]   dur;
    logic [ID_W-1:0]     xid;
    logic [ID_W-1:0]     entry_id;
    logic [ID_W-1:0]     free_idx;
    logic                free_any;
    logic                x_ok;
    logic                tick;
    logic                full;
    logic [CNT_W-1:0]    car_count;
    logic [FEE_W-1:0]    fee;
    logic [FEE_W-1:0]    fee_sat;
    logic [PROD_W-1:0]   prod;
    logic                entry_ack;
    logic                entry_reject;
    logic                exit_reject;
    logic                fee_valid;

    assign tick = (presc == PRE_W'(TICK_DIV - 1));
    assign full = (car_count == CNT_W'(NUM_SLOTS));
    assign x_ok = (32'(xid) < NUM_SLOTS) && occ[xid];
    assign prod = PROD_W'(dur) * PROD_W'(RATE);

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.entry_ack    = entry_ack;
    assign bus.entry_id     = entry_id;
    assign bus.entry_reject = entry_reject;
    assign bus.exit_reject  = exit_reject;
    assign bus.fee_valid    = fee_valid;
    assign bus.fee          = fee;
    assign bus.car_count    = car_count;
    assign bus.full         = full;
    assign bus.empty        = (car_count == '0);
    assign bus.cur_time     = cur_time;

    // Lowest-index free bay search.
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!occ[i] && !free_any) begin
                free_idx = ID_W'(i);
                free_any = 1'b1;
            end
        end
    end

    // Fee saturation: any product bit above FEE_W clamps to all-ones.
    always_comb begin
        fee_sat = FEE_W'(prod);
        if (|(prod >> FEE_W)) begin
            fee_sat = '1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, exit beats entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.exit_req) begin
                    state_d = S_XCHK;
                end else if (bus.entry_req) begin
                    state_d = S_ENT;
                end
            end
            S_ENT:  state_d = S_IDLE;
            S_XCHK: state_d = x_ok ? S_XSUB : S_IDLE;
            S_XSUB: state_d = S_XMUL;
            S_XMUL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Time base, bay bookkeeping, fee pipeline and registered response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            cur_time     <= '0;
            occ          <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                stamp[i] <= '0;
            end
            xid          <= '0;
            t_exit       <= '0;
            dur          <= '0;
            entry_id     <= '0;
            car_count    <= '0;
            fee          <= '0;
            entry_ack    <= 1'b0;
            entry_reject <= 1'b0;
            exit_reject  <= 1'b0;
            fee_valid    <= 1'b0;
        end else begin
            if (tick) begin
                presc    <= '0;
                cur_time <= cur_time + TIME_W'(1);
            end else begin
                presc <= presc + PRE_W'(1);
            end

            entry_ack    <= 1'b0;
            entry_reject <= 1'b0;
            exit_reject  <= 1'b0;
            fee_valid    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.exit_req) begin
                        xid <= bus.exit_id;
                    end
                end
                S_ENT: begin
                    if (full) begin
                        entry_reject <= 1'b1;
                    end else begin
                        occ[free_idx]   <= 1'b1;
                        stamp[free_idx] <= cur_time;
                        entry_id        <= free_idx;
                        entry_ack       <= 1'b1;
                        car_count       <= car_count + CNT_W'(1);
                    end
                end
                S_XCHK: begin
                    if (!x_ok) begin
                        exit_reject <= 1'b1;
                    end else begin
                        t_exit <= cur_time;
                    end
                end
                S_XSUB: begin
                    dur <= t_exit - stamp[xid];
                end
                S_XMUL: begin
                    fee       <= fee_sat;
                    fee_valid <= 1'b1;
                    occ[xid]  <= 1'b0;
                    car_count <= car_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
